// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: general-purpose register file with an in-flight producer
// scoreboard, sitting between decode (read/issue side) and writeback.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   rs, rt -> a, b            combinational read ports (r0 reads 0)
//   issue_valid/_dest/_wr     decode issue request; busy[dest] set on accept
//   stall                     issue blocked: a source operand is busy
//   reg_write/num_write/
//   data_write                writeback port; clears busy[num_write]
//   busy_count                registered count of busy registers
//   wb_err                    sticky: writeback to a register that was not busy
//
// BYPASS=1 forwards same-cycle writeback data to the read ports and lets the
// same writeback release a pending stall.
module gpr_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              issue_wr,
    output logic              stall,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] num_write,
    input  logic [DATA_W-1:0] data_write,
    output logic [ADDR_W:0]   busy_count,
    output logic              wb_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             busy;
    logic [NUM_REGS-1:0]             busy_next;
    logic [ADDR_W:0]                 cnt_next;

    logic wb_hit;    // writeback to a real register this cycle
    logic byp_hit;   // writeback visible combinationally to reads/stall
    logic rs_busy;
    logic rt_busy;
    logic accept;
    logic set_hit;
    logic err_hit;

    assign wb_hit  = reg_write && (num_write != '0);
    // Gated by reset_n so the read ports stay at 0 throughout reset.
    assign byp_hit = (BYPASS != 0) && reset_n && wb_hit;

    // Read ports
    always_comb begin
        a = '0;
        b = '0;
        if (rs != '0)
            a = (byp_hit && num_write == rs) ? data_write : regs[rs];
        if (rt != '0)
            b = (byp_hit && num_write == rt) ? data_write : regs[rt];
    end

    // Source-busy check; a same-cycle writeback satisfies the operand when bypassing.
    assign rs_busy = busy[rs] && (rs != '0) && !(byp_hit && num_write == rs);
    assign rt_busy = busy[rt] && (rt != '0) && !(byp_hit && num_write == rt);
    assign stall   = issue_valid && (rs_busy || rt_busy);

    assign accept  = issue_valid && !stall;
    assign set_hit = accept && issue_wr && (issue_dest != '0);
    // A writeback to a non-busy register is an error unless the same edge
    // issues a new producer to it.
    assign err_hit = wb_hit && !busy[num_write] &&
                     !(set_hit && issue_dest == num_write);

    // Clear first, then set: a new producer issued on the writeback edge stays outstanding.
    always_comb begin
        busy_next = busy;
        if (wb_hit)
            busy_next[num_write] = 1'b0;
        if (set_hit)
            busy_next[issue_dest] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_comb begin
        cnt_next = '0;
        for (int i = 1; i < NUM_REGS; i++)
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs       <= '0;
            busy       <= '0;
            busy_count <= '0;
            wb_err     <= 1'b0;
        end else begin
            if (wb_hit)
                regs[num_write] <= data_write;
            busy       <= busy_next;
            busy_count <= cnt_next;
            if (err_hit)
                wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard. Two instances share all inputs:
// u1 with BYPASS=1 and u0 with BYPASS=0, so forwarding and non-forwarding
// timing are checked against the same stimulus.
module tb_gpr_scoreboard;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  rs, rt, issue_dest, num_write;
    logic        issue_valid, issue_wr, reg_write;
    logic [31:0] data_write;

    logic [31:0] a1, b1, a0, b0;
    logic        stall1, stall0, err1, err0;
    logic [5:0]  cnt1, cnt0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    gpr_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u1 (
        .clock(clock), .reset_n(reset_n), .rs(rs), .rt(rt), .a(a1), .b(b1),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_wr(issue_wr),
        .stall(stall1), .reg_write(reg_write), .num_write(num_write),
        .data_write(data_write), .busy_count(cnt1), .wb_err(err1)
    );

    gpr_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u0 (
        .clock(clock), .reset_n(reset_n), .rs(rs), .rt(rt), .a(a0), .b(b0),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_wr(issue_wr),
        .stall(stall0), .reg_write(reg_write), .num_write(num_write),
        .data_write(data_write), .busy_count(cnt0), .wb_err(err0)
    );

    task automatic idle();
        rs = '0; rt = '0; issue_valid = 0; issue_dest = '0; issue_wr = 0;
        reg_write = 0; num_write = '0; data_write = '0;
    endtask

    // Advance one clock; inputs change 2 ns after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        idle();
        #1 reset_n = 0;
        #2 reset_n = 1;
    endtask

    task automatic test_reset();
        idle();
        // Make r3 busy and r4 written, then reset mid-cycle.
        issue_valid = 1; issue_wr = 1; issue_dest = 5'd3;
        reg_write = 1; num_write = 5'd4; data_write = 32'hDEAD_BEEF;
        tick();
        idle();
        rs = 5'd4;
        #1;
        checks++; if (cnt1 !== 6'd1 || cnt0 !== 6'd1) begin errors++;
            $display("FAIL pre_reset_count got %0d/%0d exp 1", cnt1, cnt0); end
        checks++; if (a1 !== 32'hDEAD_BEEF || err1 !== 1'b1) begin errors++;
            $display("FAIL pre_reset_state a=%h err=%b exp deadbeef 1", a1, err1); end
        reset_n = 0;
        #1;
        checks++; if (cnt1 !== 6'd0 || cnt0 !== 6'd0) begin errors++;
            $display("FAIL reset_count got %0d/%0d exp 0", cnt1, cnt0); end
        checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++;
            $display("FAIL reset_wb_err got %b/%b exp 0", err1, err0); end
        for (int i = 0; i < 32; i++) begin
            rs = 5'(i); rt = 5'(31 - i);
            #0.1;
            checks++; if (a1 !== '0 || b1 !== '0 || a0 !== '0 || b0 !== '0) begin errors++;
                $display("FAIL reset_read idx %0d got %h %h %h %h exp 0", i, a1, b1, a0, b0); end
        end
        issue_valid = 1; rs = 5'd3; rt = 5'd3;
        #0.1;
        checks++; if (stall1 !== 1'b0 || stall0 !== 1'b0) begin errors++;
            $display("FAIL reset_stall got %b/%b exp 0", stall1, stall0); end
        @(negedge clock);
        reset_n = 1;
        tick();
        // Writes to r0 are discarded and raise no error.
        idle();
        reg_write = 1; num_write = 5'd0; data_write = 32'hFFFF_FFFF;
        #1;
        checks++; if (a1 !== '0 || a0 !== '0) begin errors++;
            $display("FAIL r0_bypass got %h/%h exp 0", a1, a0); end
        tick();
        idle();
        #1;
        checks++; if (a1 !== '0 || a0 !== '0) begin errors++;
            $display("FAIL r0_read got %h/%h exp 0", a1, a0); end
        checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++;
            $display("FAIL r0_wb_err got %b/%b exp 0", err1, err0); end
    endtask

    task automatic test_basic_write();
        do_reset();
        reg_write = 1; num_write = 5'd5; data_write = 32'h1234_5678;
        rs = 5'd5; rt = 5'd5;
        #1;
        checks++; if (a1 !== 32'h1234_5678 || b1 !== 32'h1234_5678) begin errors++;
            $display("FAIL basic_bypass got %h %h exp 12345678", a1, b1); end
        checks++; if (a0 !== 32'h0) begin errors++;
            $display("FAIL basic_nobypass got %h exp 0", a0); end
        tick();
        reg_write = 0;
        #1;
        checks++; if (a1 !== 32'h1234_5678 || a0 !== 32'h1234_5678 || b0 !== 32'h1234_5678) begin errors++;
            $display("FAIL basic_read got %h %h %h exp 12345678", a1, a0, b0); end
        checks++; if (err1 !== 1'b1 || err0 !== 1'b1) begin errors++;
            $display("FAIL basic_wb_err got %b/%b exp 1", err1, err0); end
        tick();
        #1;
        checks++; if (err1 !== 1'b1 || err0 !== 1'b1) begin errors++;
            $display("FAIL basic_wb_err_sticky got %b/%b exp 1", err1, err0); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_dest = 5'd7;
        #1;
        checks++; if (stall1 !== 1'b0 || stall0 !== 1'b0) begin errors++;
            $display("FAIL raw_first_issue got %b/%b exp 0", stall1, stall0); end
        tick();
        issue_wr = 0; issue_dest = '0; rs = 5'd7;
        #1;
        checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++;
            $display("FAIL raw_stall got %b/%b exp 1", stall1, stall0); end
        checks++; if (cnt1 !== 6'd1 || cnt0 !== 6'd1) begin errors++;
            $display("FAIL raw_count got %0d/%0d exp 1", cnt1, cnt0); end
        issue_valid = 0;
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++;
            $display("FAIL raw_no_valid got %b exp 0", stall1); end
        issue_valid = 1;
        tick();
        reg_write = 1; num_write = 5'd7; data_write = 32'hA5A5_A5A5;
        #1;
        checks++; if (stall1 !== 1'b0 || a1 !== 32'hA5A5_A5A5) begin errors++;
            $display("FAIL raw_wb_bypass stall=%b a=%h exp 0 a5a5a5a5", stall1, a1); end
        checks++; if (stall0 !== 1'b1 || a0 !== 32'h0) begin errors++;
            $display("FAIL raw_wb_nobypass stall=%b a=%h exp 1 0", stall0, a0); end
        tick();
        reg_write = 0;
        #1;
        checks++; if (stall0 !== 1'b0 || a0 !== 32'hA5A5_A5A5) begin errors++;
            $display("FAIL raw_after_wb stall=%b a=%h exp 0 a5a5a5a5", stall0, a0); end
        checks++; if (cnt1 !== 6'd0 || cnt0 !== 6'd0 || err1 !== 1'b0 || err0 !== 1'b0) begin errors++;
            $display("FAIL raw_final cnt=%0d/%0d err=%b/%b exp 0 0", cnt1, cnt0, err1, err0); end
    endtask

    task automatic test_collision();
        do_reset();
        issue_valid = 1; issue_wr = 1; issue_dest = 5'd9;
        tick();
        reg_write = 1; num_write = 5'd9; data_write = 32'h0000_0099;
        #1;
        checks++; if (cnt1 !== 6'd1 || stall1 !== 1'b0 || stall0 !== 1'b0) begin errors++;
            $display("FAIL coll_setup cnt=%0d stall=%b/%b exp 1 0 0", cnt1, stall1, stall0); end
        tick();
        idle();
        issue_valid = 1; rs = 5'd9;
        #1;
        checks++; if (cnt1 !== 6'd1 || cnt0 !== 6'd1) begin errors++;
            $display("FAIL coll_count got %0d/%0d exp 1", cnt1, cnt0); end
        checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++;
            $display("FAIL coll_busy_kept got %b/%b exp 1", stall1, stall0); end
        checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++;
            $display("FAIL coll_wb_err got %b/%b exp 0", err1, err0); end
        checks++; if (a1 !== 32'h99 || a0 !== 32'h99) begin errors++;
            $display("FAIL coll_data got %h/%h exp 99", a1, a0); end
    endtask

    task automatic test_full();
        do_reset();
        for (int d = 1; d < 32; d++) begin
            issue_valid = 1; issue_wr = 1; issue_dest = 5'(d);
            tick();
        end
        idle();
        #1;
        checks++; if (cnt1 !== 6'd31 || cnt0 !== 6'd31) begin errors++;
            $display("FAIL full_count got %0d/%0d exp 31", cnt1, cnt0); end
        rs = 5'd31;
        #1;
        checks++; if (stall1 !== 1'b0) begin errors++;
            $display("FAIL full_no_valid got %b exp 0", stall1); end
        issue_valid = 1;
        #1;
        checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++;
            $display("FAIL full_stall_rs got %b/%b exp 1", stall1, stall0); end
        rs = 5'd0; rt = 5'd31;
        #1;
        checks++; if (stall1 !== 1'b1 || stall0 !== 1'b1) begin errors++;
            $display("FAIL full_stall_rt got %b/%b exp 1", stall1, stall0); end
        idle();
        for (int d = 1; d < 32; d++) begin
            reg_write = 1; num_write = 5'(d); data_write = 32'(d * 3);
            tick();
        end
        idle();
        rs = 5'd17; rt = 5'd31;
        #1;
        checks++; if (cnt1 !== 6'd0 || cnt0 !== 6'd0) begin errors++;
            $display("FAIL full_drain_count got %0d/%0d exp 0", cnt1, cnt0); end
        checks++; if (err1 !== 1'b0 || err0 !== 1'b0) begin errors++;
            $display("FAIL full_wb_err got %b/%b exp 0", err1, err0); end
        checks++; if (a1 !== 32'd51 || b0 !== 32'd93) begin errors++;
            $display("FAIL full_data got %0d/%0d exp 51 93", a1, b0); end
    endtask

    initial begin
        idle();
        reset_n = 0;
        #12 reset_n = 1;
        tick();
        test_reset();
        test_basic_write();
        test_raw_stall();
        test_collision();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
